// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder constants: prefix/command bytes, ps2_key field layout
// and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;

  localparam int STB   = 10;
  localparam int PRS   = 9;
  localparam int EXT   = 8;
  localparam int KEY_W = 11;

  typedef logic [KEY_W-1:0] ps2_key_t;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Pad-side PS/2 lines and the decoded key/byte bus of ps2_key_decoder.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  ps2_key_t   ps2_key;
  logic       frame_err;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (
    input  ps2_clk, ps2_data,
    output ps2_key, frame_err, byte_valid, byte_data
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  ps2_key, frame_err, byte_valid, byte_data
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus debounce: the output level follows the line only
// after FILTER_LEN consecutive differing samples. Idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Metastability synchroniser for the asynchronous pad line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= line_in;
      sync2_r <= sync1_r;
    end
  end

  // Run length of samples disagreeing with the accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
    end else if (sync2_r == level_r) begin
      level_r <= level_r;
      cnt_r   <= '0;
    end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
      level_r <= sync2_r;
      cnt_r   <= '0;
    end else begin
      level_r <= level_r;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  assign level_out = level_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters the pad lines, assembles 11-bit frames and
// merges E0/F0 prefixes into one toggle-strobed event per key on ps2_key.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  ps2_key_decoder_if.master   bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SKIP = 1'b1;

  logic          clk_filt_s;
  logic          data_filt_s;
  logic          clk_prev_r;
  logic          fall_s;
  logic [3:0]    bit_cnt_r;
  logic [8:0]    shift_r;
  logic [TW-1:0] to_cnt_r;
  logic          good_s;
  logic          bad_s;
  logic          timeout_s;
  logic          err_s;

  logic [0:0]    state_r;
  logic          ext_r;
  logic          rel_r;
  logic [2:0]    skip_r;
  ps2_key_t      key_r;
  logic          frame_err_r;
  logic          byte_valid_r;
  logic [7:0]    byte_data_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (bus.ps2_clk),
    .level_out (clk_filt_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (bus.ps2_data),
    .level_out (data_filt_s)
  );

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_r <= 1'b1;
    end else begin
      clk_prev_r <= clk_filt_s;
    end
  end

  assign fall_s = clk_prev_r & ~clk_filt_s;

  // Stop-bit verdict and mid-frame timeout.
  always_comb begin
    good_s    = 1'b0;
    bad_s     = 1'b0;
    timeout_s = 1'b0;
    if (fall_s && (bit_cnt_r == 4'd10)) begin
      if (data_filt_s && odd_parity_ok(shift_r)) begin
        good_s = 1'b1;
      end else begin
        bad_s = 1'b1;
      end
    end else begin
      good_s = 1'b0;
      bad_s  = 1'b0;
    end
    if ((bit_cnt_r != 4'd0) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYC - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  assign err_s = bad_s | timeout_s;

  // Bit counter and LSB-first shifter; a high start bit is treated as noise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 9'd0;
    end else if (timeout_s) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= shift_r;
    end else if (fall_s) begin
      case (bit_cnt_r)
        4'd0: begin
          bit_cnt_r <= data_filt_s ? 4'd0 : 4'd1;
          shift_r   <= shift_r;
        end
        4'd10: begin
          bit_cnt_r <= 4'd0;
          shift_r   <= shift_r;
        end
        default: begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
          shift_r   <= {data_filt_s, shift_r[8:1]};
        end
      endcase
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  // Idle-cycle counter, only armed while a frame is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r <= '0;
    end else if ((bit_cnt_r == 4'd0) || fall_s || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Debug byte stream and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r  <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
    end else begin
      frame_err_r  <= err_s;
      byte_valid_r <= good_s;
      byte_data_r  <= good_s ? shift_r[7:0] : byte_data_r;
    end
  end

  // Prefix merging and event generation; key bits only move with the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ext_r   <= 1'b0;
      rel_r   <= 1'b0;
      skip_r  <= 3'd0;
      key_r   <= '0;
    end else if (err_s) begin
      state_r <= ST_IDLE;
      ext_r   <= 1'b0;
      rel_r   <= 1'b0;
      skip_r  <= 3'd0;
    end else if (good_s) begin
      case (state_r)
        ST_IDLE: begin
          case (shift_r[7:0])
            PS2_EXT: ext_r <= 1'b1;
            PS2_REL: rel_r <= 1'b1;
            PS2_PAUSE: begin
              state_r <= ST_SKIP;
              skip_r  <= 3'd7;
              ext_r   <= 1'b0;
              rel_r   <= 1'b0;
            end
            PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_OVR_LO, PS2_OVR_HI: begin
              ext_r <= 1'b0;
              rel_r <= 1'b0;
            end
            default: begin
              key_r[STB]   <= ~key_r[STB];
              key_r[PRS]   <= ~rel_r;
              key_r[EXT]   <= ext_r;
              key_r[7:0]   <= shift_r[7:0];
              ext_r        <= 1'b0;
              rel_r        <= 1'b0;
            end
          endcase
        end
        ST_SKIP: begin
          skip_r  <= skip_r - 3'd1;
          state_r <= (skip_r == 3'd1) ? ST_IDLE : ST_SKIP;
        end
        default: begin
          state_r <= ST_IDLE;
          skip_r  <= 3'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign bus.ps2_key    = key_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_data  = byte_data_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: bit-banged PS/2 frames, a byte and
// event scoreboard checked by a monitor, plus per-scenario end checks.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int bv_cnt = 0;
  int err_cnt = 0;
  int evt_cnt = 0;

  logic [10:0] exp_key_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [10:0] last_key = 11'h000;
  logic [10:0] mon_key;
  logic [7:0]  mon_byte;

  // Scoreboard monitor: pops expected bytes/events as the DUT produces them.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_key = 11'h000;
    end else begin
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.byte_valid === 1'b1) begin
        bv_cnt++;
        checks++;
        if (exp_byte_q.size() == 0) begin
          failures++;
          $display("FAIL byte_unexpected got=%h expected=none", bus.byte_data);
        end else begin
          mon_byte = exp_byte_q.pop_front();
          if (bus.byte_data !== mon_byte) begin
            failures++;
            $display("FAIL byte_data got=%h expected=%h", bus.byte_data, mon_byte);
          end
        end
      end
      if (bus.ps2_key !== last_key) begin
        evt_cnt++;
        checks++;
        if (exp_key_q.size() == 0) begin
          failures++;
          $display("FAIL key_unexpected got=%h expected=none", bus.ps2_key);
        end else begin
          mon_key = exp_key_q.pop_front();
          if (bus.ps2_key !== mon_key) begin
            failures++;
            $display("FAIL key_event got=%h expected=%h", bus.ps2_key, mon_key);
          end
        end
        checks++;
        if ((bus.ps2_key[STB] === last_key[STB]) || (bus.byte_valid !== 1'b1)) begin
          failures++;
          $display("FAIL strobe_rule got=%h prev=%h byte_valid=%b expected=toggle_with_byte_valid",
                   bus.ps2_key, last_key, bus.byte_valid);
        end
        last_key = bus.ps2_key;
      end
    end
  end

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    if (!bad_par) exp_byte_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic settle(input string name);
    repeat (50) @(negedge clk);
    checks++;
    if ((exp_key_q.size() != 0) || (exp_byte_q.size() != 0)) begin
      failures++;
      $display("FAIL %s_drain got=keys:%0d,bytes:%0d expected=0,0", name,
               exp_key_q.size(), exp_byte_q.size());
      exp_key_q.delete();
      exp_byte_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    checks += 4;
    if (bus.ps2_key !== 11'h000) begin failures++; $display("FAIL rst_key got=%h expected=000", bus.ps2_key); end
    if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b expected=0", bus.frame_err); end
    if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL rst_bv got=%b expected=0", bus.byte_valid); end
    if (bus.byte_data !== 8'h00) begin failures++; $display("FAIL rst_bd got=%h expected=00", bus.byte_data); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_make();
    int b0 = bv_cnt;
    int e0 = err_cnt;
    exp_key_q.push_back(11'h61C);
    send_byte(8'h1C, 1'b0);
    settle("make");
    checks += 3;
    if (bus.ps2_key !== 11'h61C) begin failures++; $display("FAIL make_key got=%h expected=61C", bus.ps2_key); end
    if (bv_cnt - b0 != 1) begin failures++; $display("FAIL make_bv got=%0d expected=1", bv_cnt - b0); end
    if (err_cnt != e0) begin failures++; $display("FAIL make_err got=%0d expected=0", err_cnt - e0); end
  endtask

  task automatic test_break();
    int v0 = evt_cnt;
    exp_key_q.push_back(11'h01C);
    send_byte(8'hF0, 1'b0);
    checks++;
    if (evt_cnt != v0) begin failures++; $display("FAIL break_prefix_evt got=%0d expected=0", evt_cnt - v0); end
    send_byte(8'h1C, 1'b0);
    settle("break");
    checks++;
    if (bus.ps2_key !== 11'h01C) begin failures++; $display("FAIL break_key got=%h expected=01C", bus.ps2_key); end
  endtask

  task automatic test_extended();
    exp_key_q.push_back(11'h775);
    exp_key_q.push_back(11'h175);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    settle("ext");
    checks++;
    if (bus.ps2_key[8:0] !== 9'h175) begin failures++; $display("FAIL ext_key got=%h expected=175", bus.ps2_key[8:0]); end
  endtask

  task automatic test_bad_parity();
    int e0 = err_cnt;
    int b0 = bv_cnt;
    send_byte(8'h1C, 1'b1);
    repeat (20) @(negedge clk);
    checks += 3;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL par_err got=%0d expected=1", err_cnt - e0); end
    if (bv_cnt != b0) begin failures++; $display("FAIL par_bv got=%0d expected=0", bv_cnt - b0); end
    if (bus.ps2_key !== 11'h175) begin failures++; $display("FAIL par_key got=%h expected=175", bus.ps2_key); end
    exp_key_q.push_back(11'h61C);
    send_byte(8'h1C, 1'b0);
    settle("par");
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL tmo_err got=%0d expected=1", err_cnt - e0); end
    exp_key_q.push_back(11'h229);
    send_byte(8'h29, 1'b0);
    settle("tmo");
    checks++;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL tmo_err_after got=%0d expected=1", err_cnt - e0); end
  endtask

  task automatic test_pause();
    logic [7:0] seq[9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};
    int v0 = evt_cnt;
    exp_key_q.push_back(11'h65A);
    for (int i = 0; i < 9; i++) send_byte(seq[i], 1'b0);
    settle("pause");
    checks += 2;
    if (evt_cnt - v0 != 1) begin failures++; $display("FAIL pause_evts got=%0d expected=1", evt_cnt - v0); end
    if (bus.ps2_key[9:0] !== 10'h25A) begin failures++; $display("FAIL pause_key got=%h expected=25A", bus.ps2_key[9:0]); end
  endtask

  task automatic test_glitch();
    int e0 = err_cnt;
    int lens[2] = '{1, FILT - 1};
    for (int g = 0; g < 2; g++) begin
      bus.ps2_data = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (lens[g]) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    exp_key_q.push_back(11'h21C);
    send_byte(8'h1C, 1'b0);
    settle("glitch");
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL glitch_err got=%0d expected=0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    exp_key_q.push_back(11'h61C);
    exp_key_q.push_back(11'h21C);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    settle("b2b");
    checks++;
    if (bus.ps2_key !== 11'h21C) begin failures++; $display("FAIL b2b_key got=%h expected=21C", bus.ps2_key); end
  endtask

  task automatic test_mid_reset();
    int e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ps2_key !== 11'h000) begin failures++; $display("FAIL midrst_key got=%h expected=000", bus.ps2_key); end
    bus.ps2_data = 1'b1;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_key_q.push_back(11'h61C);
    send_byte(8'h1C, 1'b0);
    settle("midrst");
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL midrst_err got=%0d expected=0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_bad_parity();
    test_timeout();
    test_pause();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
